alu_addsub_seq: RTL
===================

Name: alu_addsub_seq

Overview:
- Byte-serial WIDTH-bit add/subtract unit for the RV32 ALU area-reduced configuration.
- Sits directly upstream of a single 8-bit CLA slice and sequences one operand byte per cycle through it, registering the carry between slices.
- Result and flags are presented to the ALU result mux through a valid/ready handshake.
- Trades latency (WIDTH/8 cycles) for one slice of adder area.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, slice width; fixed to match the 8-bit adder cell.
- NSLICE, WIDTH/SLICE, derived localparam; number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- flush  in  1  synchronous abort of in-flight op (pipeline kill).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1 after reset release; out_valid=0.
  - sum=0, c_out=0, ovf=0, zero=0.
  - Slice index=0, carry register=0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a; latch b XOR {WIDTH{sub}}; carry reg = sub; idx = 0; go RUN.
- RUN, one slice per cycle:
  - Slice inputs: a[idx*8 +: 8], b'[idx*8 +: 8], carry reg.
  - Slice output is written to sum[idx*8 +: 8]; the slice carry-out is written to the carry reg.
  - idx increments each cycle.
  - After slice NSLICE-1 is processed, go DONE.
  - Before overwriting the carry reg at the last slice, capture the carry into the MSB as a[W-1]^b'[W-1]^sum[W-1].
- DONE:
  - out_valid=1. sum/c_out/ovf/zero are stable and held until out_ready=1.
  - c_out = final carry reg.
  - ovf = carry_into_msb XOR c_out.
  - zero = (sum==0).
  - On out_ready: go IDLE; out_valid drops the next cycle; sum/flags hold their last values.
- Latency: accept at edge N -> out_valid high from edge N+NSLICE (4 cycles for 32-bit).
- Throughput: one op per NSLICE+2 cycles with out_ready tied high.
- No bypass: in_ready=0 in DONE even when out_ready=1; the next op is accepted in IDLE.
- Flags are only meaningful while out_valid=1. sum is partially updated during RUN and must not be sampled then.
- flush:
  - Synchronous, highest priority over all transitions. Any state -> IDLE next cycle.
  - out_valid=0, idx=0.
  - in_valid in the same cycle as flush is ignored.
- in_valid held while busy: ignored; the requester must hold the request until in_ready.
- Reset mid-RUN or mid-DONE: immediate abort, all outputs go to their reset values, and no stale out_valid appears after release.
- Operands a/b/sub may change after acceptance without affecting the in-flight result.

Decomposition:
- Shared ALU package:
  - SLICE width constant.
  - FSM state enum {IDLE, RUN, DONE} (2-bit).
  - ALU op encoding for add/sub.
- Sub-module: instantiate the team's existing 8-bit CLA cell add8 once as the slice adder.
  - No behavioural "+" on the slice path.
- The top level holds the FSM, operand/result registers, carry reg, idx counter ($clog2(NSLICE) bits) and flag logic.

Test Plan:
- Add 0xFFFFFFFF + 0x00000001, out_ready=1 -> after 4 cycles: out_valid=1, sum=0x00000000, c_out=1, ovf=0, zero=1.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, c_out=0, ovf=1, zero=0.
- Sub 0x00000000 - 0x00000001 -> sum=0xFFFFFFFF, c_out=0 (borrow), ovf=0.
- Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, c_out=1, ovf=1.
- Backpressure: add 0x12345678 + 0x11111111, out_ready=0 for 3 cycles in DONE:
  - out_valid stays 1 and sum stays 0x23456789 throughout; in_ready=0.
  - in_valid pulses during this window are ignored.
  - out_ready=1 -> IDLE next cycle.
- Abort:
  - flush asserted at the 3rd RUN cycle -> IDLE next cycle, out_valid never asserts, in_ready=1.
  - rst_n pulsed low mid-RUN -> all outputs 0 immediately.
  - A fresh op 0x00000005 + 0x00000003 then yields sum=0x00000008 in 4 cycles.

Source files
------------

// File: rtl/alu_addsub_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract unit.
//   ALU_SLICE_W : width of the single adder slice the unit is sequenced through
//   state_e     : top-level sequencing FSM states
//   alu_op_e    : add/sub operation encoding (matches the 'sub' request bit)
package alu_addsub_seq_pkg;

  localparam int ALU_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/alu_addsub_seq_add8.sv
// add8: 8-bit carry-lookahead adder cell.
//   a_i, b_i : 8-bit addends
//   c_i      : carry in
//   s_o      : 8-bit sum
//   c_o      : carry out of bit 7
// Two 4-bit lookahead groups; the group carry ripples from the low group
// into the high group.
module add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);

  // Returns the carries into bits 1..4 of a 4-bit group, {c4,c3,c2,c1}.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic c1, c2, c3, c4;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, c3, c2, c1};
  endfunction

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] c_lo;
  logic [3:0] c_hi;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c_lo = cla4(g[3:0], p[3:0], c_i);
  assign c_hi = cla4(g[7:4], p[7:4], c_lo[3]);
  assign s_o  = p ^ {c_hi[2:0], c_lo[3], c_lo[2:0], c_i};
  assign c_o  = c_hi[3];

endmodule

// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: byte-serial WIDTH-bit add/subtract unit.
// One SLICE-wide chunk of the operands goes through a single add8 cell per
// cycle, with the inter-slice carry held in a register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   a, b, sub            : operands and op (sub=1 -> a-b)
//   flush                : synchronous abort, returns to IDLE
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, c_out, ovf, zero: result and flags, held after DONE
module alu_addsub_seq import alu_addsub_seq_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SLICE = ALU_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;      // b already conditionally inverted
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  alu_op_e           op;
  int                base;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_s;
  logic              slice_co;

  assign op      = alu_op_e'(sub);
  assign base    = int'(idx_q) * SLICE;
  assign slice_a = a_q[base +: SLICE];
  assign slice_b = b_q[base +: SLICE];

  add8 u_add8 (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            a_d     = a;
            b_d     = (op == OP_SUB) ? ~b : b;
            carry_d = (op == OP_SUB);
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          sum_d[base +: SLICE] = slice_s;
          carry_d              = slice_co;
          idx_d                = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DONE;
            c_out_d = slice_co;
            // Carry into the MSB recovered from the MSB sum bit; it differs
            // from the carry out exactly when signed overflow occurred.
            ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE-1]) ^ slice_co;
            zero_d  = (sum_d == '0);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
